// File: rtl/dds_multichannel_core.sv
// rtl/dds_multichannel_core.sv - N-channel arithmetic DDS engine with a register write port
// Optional macro DDS_SWEEP_EN adds a per-channel linear frequency sweep (addrs 4/5).
module dds_multichannel_core #(
   parameter int  NUM_CH  = 4,
   parameter int  PHASE_W = 32,
   parameter int  OUT_W   = 16,
   parameter int  AMP_W   = 8,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    sample_en,
   input  logic                    wr_en,
   input  logic [CH_W-1:0]         wr_ch,
   input  logic [2:0]              wr_addr,
   input  logic [PHASE_W-1:0]      wr_data,
   output logic                    out_valid,
   output logic [NUM_CH*OUT_W-1:0] wave_out
);

   localparam logic [OUT_W-1:0] MID      = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] PAR_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
   localparam int               PW       = OUT_W + AMP_W + 2;
   localparam logic [CH_W:0]    NUM_CH_L = (CH_W+1)'(NUM_CH);

   localparam logic [2:0] A_FREQ = 3'd0;
   localparam logic [2:0] A_OFS  = 3'd1;
   localparam logic [2:0] A_WAVE = 3'd2;
   localparam logic [2:0] A_AMP  = 3'd3;
   localparam logic [2:0] A_STEP = 3'd4;
   localparam logic [2:0] A_STOP = 3'd5;
   localparam logic [2:0] A_SYNC = 3'd7;

   logic [PHASE_W-1:0] acc       [NUM_CH];
   logic [PHASE_W-1:0] freq      [NUM_CH];
   logic [PHASE_W-1:0] ofs       [NUM_CH];
   logic [1:0]         wave      [NUM_CH];
   logic [AMP_W-1:0]   amp       [NUM_CH];
   logic [OUT_W-1:0]   shape_q   [NUM_CH];
   logic [AMP_W-1:0]   amp_q     [NUM_CH];
   logic [OUT_W-1:0]   out_q     [NUM_CH];
   logic [PHASE_W-1:0] phase_sum [NUM_CH];
   logic [OUT_W-1:0]   shape_d   [NUM_CH];
   logic [OUT_W-1:0]   scaled_d  [NUM_CH];
   logic [NUM_CH-1:0]  ch_sel;
   logic               wr_ok;
   logic               sync_hit;
   logic               s1_valid;

`ifdef DDS_SWEEP_EN
   logic [PHASE_W-1:0] sweep_step  [NUM_CH];
   logic [PHASE_W-1:0] sweep_stop  [NUM_CH];
   logic [PHASE_W-1:0] sweep_start [NUM_CH];
   logic [PHASE_W:0]   sweep_sum   [NUM_CH];
   logic [NUM_CH-1:0]  sweep_wrap;
`endif

   // Parabolic half-wave: peak of u*(MID-u) lands exactly on MID, so clamp one below.
   function automatic logic [OUT_W-1:0] shape_fn(input logic [1:0] w, input logic [OUT_W-1:0] p);
      logic [OUT_W-2:0]   u;
      logic               m;
      logic [OUT_W-1:0]   comp;
      logic [2*OUT_W-2:0] prod;
      logic [2*OUT_W-2:0] par_w;
      logic [OUT_W-1:0]   par;
      logic [OUT_W-1:0]   res;
      u     = p[OUT_W-2:0];
      m     = p[OUT_W-1];
      comp  = MID - {1'b0, u};
      prod  = {{OUT_W{1'b0}}, u} * {{(OUT_W-1){1'b0}}, comp};
      par_w = prod >> (OUT_W-3);
      par   = (par_w > {{(OUT_W-1){1'b0}}, PAR_MAX}) ? PAR_MAX : par_w[OUT_W-1:0];
      case (w)
         2'b00:   res = m ? (MID - par) : (MID + par);
         2'b01:   res = m ? '0 : '1;
         2'b10:   res = m ? ~{u, 1'b0} : {u, 1'b0};
         default: res = p;
      endcase
      return res;
   endfunction

   // Scale around midscale; the arithmetic shift floors toward minus infinity.
   function automatic logic [OUT_W-1:0] scale_fn(input logic [OUT_W-1:0] sh, input logic [AMP_W-1:0] a);
      logic signed [OUT_W:0] s;
      logic signed [PW-1:0]  s_ext;
      logic signed [PW-1:0]  a_ext;
      logic signed [PW-1:0]  prod;
      logic signed [PW-1:0]  shf;
      logic [OUT_W:0]        sum;
      s     = $signed({1'b0, sh} - {1'b0, MID});
      s_ext = {{(AMP_W+1){s[OUT_W]}}, s};
      a_ext = {{(OUT_W+2){1'b0}}, a};
      prod  = s_ext * a_ext;
      shf   = prod >>> AMP_W;
      sum   = {1'b0, MID} + shf[OUT_W:0];
      return sum[OUT_W-1:0];
   endfunction

   assign wr_ok    = wr_en && ({1'b0, wr_ch} < NUM_CH_L);
   assign sync_hit = wr_en && (wr_addr == A_SYNC) && wr_data[0];

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         ch_sel[k]    = wr_ok && (wr_ch == CH_W'(k));
         phase_sum[k] = acc[k] + ofs[k];
         shape_d[k]   = shape_fn(wave[k], phase_sum[k][PHASE_W-1 -: OUT_W]);
         scaled_d[k]  = scale_fn(shape_q[k], amp_q[k]);
      end
   end

`ifdef DDS_SWEEP_EN
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         sweep_sum[k]  = {1'b0, freq[k]} + {1'b0, sweep_step[k]};
         sweep_wrap[k] = sweep_sum[k] >= {1'b0, sweep_stop[k]};
      end
   end
`endif

   // Channel registers; SYNC beats sample_en, and a FREQ write beats the sweep update.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_CH; k++) begin
            acc[k]  <= '0;
            freq[k] <= '0;
            ofs[k]  <= '0;
            wave[k] <= '0;
            amp[k]  <= '1;
`ifdef DDS_SWEEP_EN
            sweep_step[k]  <= '0;
            sweep_stop[k]  <= '0;
            sweep_start[k] <= '0;
`endif
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (sync_hit)
               acc[k] <= '0;
            else if (sample_en)
               acc[k] <= acc[k] + freq[k];

            if (ch_sel[k] && (wr_addr == A_FREQ)) begin
               freq[k] <= wr_data;
`ifdef DDS_SWEEP_EN
               sweep_start[k] <= wr_data;
`endif
            end
`ifdef DDS_SWEEP_EN
            else if (sample_en && (sweep_step[k] != '0))
               freq[k] <= sweep_wrap[k] ? sweep_start[k] : sweep_sum[k][PHASE_W-1:0];
`endif

            if (ch_sel[k]) begin
               case (wr_addr)
                  A_OFS:  ofs[k]  <= wr_data;
                  A_WAVE: wave[k] <= wr_data[1:0];
                  A_AMP:  amp[k]  <= wr_data[AMP_W-1:0];
`ifdef DDS_SWEEP_EN
                  A_STEP: sweep_step[k] <= wr_data;
                  A_STOP: sweep_stop[k] <= wr_data;
`endif
                  default: ;
               endcase
            end
         end
      end
   end

   // Two-stage sample pipeline: shape+amp capture, then scaling.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            shape_q[k] <= MID;
            amp_q[k]   <= '1;
            out_q[k]   <= MID;
         end
      end else begin
         s1_valid  <= sample_en;
         out_valid <= s1_valid;
         for (int k = 0; k < NUM_CH; k++) begin
            if (sample_en) begin
               shape_q[k] <= shape_d[k];
               amp_q[k]   <= amp[k];
            end
            if (s1_valid)
               out_q[k] <= scaled_d[k];
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      assign wave_out[g*OUT_W +: OUT_W] = out_q[g];
   end

endmodule
